// File: rtl/window_register_file_pkg.sv
// Shared constants and the register-number-to-physical-index mapping
// for the windowed register file.
package window_pkg;

  localparam int NGLOBALS     = 8;
  localparam int REGS_PER_WIN = 16;
  localparam int REG_ADDR_W   = 5;

  // Map architectural register r in window w onto the flat physical array.
  // Globals sit at the bottom, then 16 registers (outs + locals) per window.
  // The ins of window w are the outs of window (w+1) mod nwin.
  function automatic int phys_idx(input int r, input int w, input int nwin);
    int w_next;
    w_next = (w + 1 >= nwin) ? 0 : w + 1;
    if (r < 8) begin
      return r;
    end else if (r < 16) begin
      return NGLOBALS + REGS_PER_WIN * w + (r - 8);
    end else if (r < 24) begin
      return NGLOBALS + 8 + REGS_PER_WIN * w + (r - 16);
    end else begin
      return NGLOBALS + REGS_PER_WIN * w_next + (r - 24);
    end
  endfunction

endpackage

// File: rtl/window_register_file_if.sv
// Bus bundle for the windowed register file: read/write ports, window
// control requests and window status outputs.
interface window_register_file_if #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8
);
  import window_pkg::*;

  localparam int CWPW = $clog2(NWINDOWS);

  // There is no valid/ready handshake: every request strobe (file_enable,
  // save, restore, cwp_load, wim_load) is a single-cycle command sampled on
  // each rising clock edge and is always accepted; there is no back-pressure.
  logic                  file_enable;
  logic [REG_ADDR_W-1:0] in_PC;
  logic [WIDTH-1:0]      file_in;
  logic [REG_ADDR_W-1:0] in_PA;
  logic [REG_ADDR_W-1:0] in_PB;
  logic [WIDTH-1:0]      out_PA;
  logic [WIDTH-1:0]      out_PB;
  logic                  save;
  logic                  restore;
  logic                  cwp_load;
  logic [CWPW-1:0]       cwp_in;
  logic                  wim_load;
  logic [NWINDOWS-1:0]   wim_in;
  logic [CWPW-1:0]       cwp_out;
  logic [NWINDOWS-1:0]   wim_out;
  logic                  win_overflow;
  logic                  win_underflow;

  modport master (
    output file_enable, in_PC, file_in, in_PA, in_PB,
    output save, restore, cwp_load, cwp_in, wim_load, wim_in,
    input  out_PA, out_PB, cwp_out, wim_out, win_overflow, win_underflow
  );

  modport slave (
    input  file_enable, in_PC, file_in, in_PA, in_PB,
    input  save, restore, cwp_load, cwp_in, wim_load, wim_in,
    output out_PA, out_PB, cwp_out, wim_out, win_overflow, win_underflow
  );

endinterface

// File: rtl/window_register_file_addr_map.sv
// Combinational decode of (register number, window) to a physical index.
module window_addr_map
  import window_pkg::*;
#(
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 3,
  parameter int PHYS_W   = 8
) (
  input  logic [REG_ADDR_W-1:0] i_reg,
  input  logic [CWPW-1:0]       i_win,
  output logic [PHYS_W-1:0]     o_idx
);

  // Pure table lookup through the shared mapping function.
  always_comb begin
    o_idx = PHYS_W'(phys_idx(int'(i_reg), int'(i_win), NWINDOWS));
  end

endmodule

// File: rtl/window_register_file.sv
// Windowed register file that owns CWP and WIM: two combinational read
// ports, one synchronous write port, SAVE/RESTORE with overflow/underflow
// trap pulses.
module window_register_file
  import window_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8
) (
  input logic                  Clk,
  input logic                  Clr,
  window_register_file_if.slave bus
);

  localparam int CWPW   = $clog2(NWINDOWS);
  localparam int NPHYS  = NGLOBALS + REGS_PER_WIN * NWINDOWS;
  localparam int PHYS_W = $clog2(NPHYS);

  logic [WIDTH-1:0]    r_regs [0:NPHYS-1];
  logic [CWPW-1:0]     r_cwp;
  logic [NWINDOWS-1:0] r_wim;
  logic                r_ovf;
  logic                r_unf;

  logic [CWPW-1:0]     w_cwp_dec;
  logic [CWPW-1:0]     w_cwp_inc;
  logic [CWPW-1:0]     w_cwp_next;
  logic [CWPW-1:0]     w_wr_win;
  logic                w_wr_en;
  logic                w_ovf;
  logic                w_unf;
  logic [PHYS_W-1:0]   w_idx_a;
  logic [PHYS_W-1:0]   w_idx_b;
  logic [PHYS_W-1:0]   w_idx_c;

  // Read ports decode with the current window; the write port decodes with
  // whichever window the instruction lands in (new window for SAVE/RESTORE).
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PHYS_W(PHYS_W)) u_map_a (
    .i_reg (bus.in_PA),
    .i_win (r_cwp),
    .o_idx (w_idx_a)
  );

  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PHYS_W(PHYS_W)) u_map_b (
    .i_reg (bus.in_PB),
    .i_win (r_cwp),
    .o_idx (w_idx_b)
  );

  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PHYS_W(PHYS_W)) u_map_c (
    .i_reg (bus.in_PC),
    .i_win (w_wr_win),
    .o_idx (w_idx_c)
  );

  // Modulo-N neighbours of the current window; exact for any N, not just powers of 2.
  always_comb begin
    w_cwp_dec = (r_cwp == '0) ? CWPW'(NWINDOWS - 1) : r_cwp - CWPW'(1);
    w_cwp_inc = (r_cwp == CWPW'(NWINDOWS - 1)) ? '0 : r_cwp + CWPW'(1);
  end

  // Priority mux: cwp_load > save&restore (illegal, hold) > save > restore.
  // Trap checks look at the WIM as it was before any same-edge WIM load.
  always_comb begin
    w_cwp_next = r_cwp;
    w_wr_win   = r_cwp;
    w_wr_en    = bus.file_enable && (bus.in_PC != '0);
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    if (bus.cwp_load) begin
      if (int'(bus.cwp_in) < NWINDOWS) begin
        w_cwp_next = bus.cwp_in;
      end
    end else if (bus.save && bus.restore) begin
      w_cwp_next = r_cwp;
    end else if (bus.save) begin
      if (r_wim[w_cwp_dec]) begin
        w_ovf   = 1'b1;
        w_wr_en = 1'b0;
      end else begin
        w_cwp_next = w_cwp_dec;
        w_wr_win   = w_cwp_dec;
      end
    end else if (bus.restore) begin
      if (r_wim[w_cwp_inc]) begin
        w_unf   = 1'b1;
        w_wr_en = 1'b0;
      end else begin
        w_cwp_next = w_cwp_inc;
        w_wr_win   = w_cwp_inc;
      end
    end
  end

  // Physical register storage; phys 0 is never written, r0 reads as zero.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < NPHYS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_idx_c] <= bus.file_in;
    end
  end

  // Window pointer, invalid mask and one-cycle trap pulses.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_cwp <= '0;
      r_wim <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cwp <= w_cwp_next;
      if (bus.wim_load) begin
        r_wim <= bus.wim_in;
      end
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end
  end

  // Combinational reads with no write bypass.
  always_comb begin
    bus.out_PA        = (bus.in_PA == '0) ? '0 : r_regs[w_idx_a];
    bus.out_PB        = (bus.in_PB == '0) ? '0 : r_regs[w_idx_b];
    bus.cwp_out       = r_cwp;
    bus.wim_out       = r_wim;
    bus.win_overflow  = r_ovf;
    bus.win_underflow = r_unf;
  end

endmodule
